morse_key_classifier: RTL and testbench



---
 rtl/morse_key_classifier.sv | 233 +++++++++++++++++++++++
 tb/tb_morse_key_classifier.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_classifier.sv
// -----------------------------------------------------------------------------
// morse_key_classifier
//   Front end for a straight Morse key. The raw key level is synchronised,
//   debounced, and timed. Each press is classified as a Dot or Dash, and each
//   gap as intra-character, Space (end of character) or EndSeq (end of
//   sequence). Every symbol is emitted as a pulse held PULSE_LEN cycles, so a
//   slower clk/10 domain can sample it.
//
// Ports
//   clk     : system clock
//   Reset   : synchronous, active-high reset
//   Key     : raw asynchronous key level, 1 = pressed
//   Dot     : Dot pulse, PULSE_LEN cycles
//   Dash    : Dash pulse, PULSE_LEN cycles
//   Space   : Space pulse, PULSE_LEN cycles
//   EndSeq  : EndSeq pulse, PULSE_LEN cycles
//   KeyDb   : debounced key level
//   Overrun : sticky, set when a symbol was dropped (pulse and slot both busy)
//
// Internal handshake: req_valid/req_sym is a single-cycle strobe from the
// classifier to the emitter with no backpressure. In the cycle it is seen,
// the emitter either starts the symbol, parks it in the 1-deep pending slot,
// or drops it and sets Overrun.
// -----------------------------------------------------------------------------
module morse_key_classifier #(
   parameter int CNT_W     = 16,
   parameter int DEBOUNCE  = 4,
   parameter int DOT_MIN   = 8,
   parameter int DASH_MIN  = 40,
   parameter int SPACE_GAP = 60,
   parameter int END_GAP   = 140,
   parameter int PULSE_LEN = 10
) (
   input  logic clk,
   input  logic Reset,
   input  logic Key,
   output logic Dot,
   output logic Dash,
   output logic Space,
   output logic EndSeq,
   output logic KeyDb,
   output logic Overrun
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam int PL_W = $clog2(PULSE_LEN + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_t;
   typedef enum logic [1:0] {SYM_DOT, SYM_DASH, SYM_SPACE, SYM_END} sym_t;

   // ---------------------------------------------------------------- sync + debounce
   logic            s1, s2;
   logic [DB_W-1:0] db_cnt;

   always_ff @(posedge clk) begin
      if (Reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         db_cnt <= '0;
         KeyDb  <= 1'b0;
      end else begin
         s1 <= Key;
         s2 <= s1;
         if (s2 != KeyDb) begin
            // KeyDb follows s2 only after DEBOUNCE consecutive mismatching cycles
            if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
               KeyDb  <= s2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // ---------------------------------------------------------------- classifier FSM
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic             char_q, char_nxt;   // Dot/Dash seen since last Space
   logic             seq_q, seq_nxt;     // Dot/Dash seen since last EndSeq
   logic             is_short, is_dash, at_space, at_end;
   logic             req_valid;
   sym_t             req_sym;

   assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;   // saturating
   assign is_short = cnt <  CNT_W'(DOT_MIN);
   assign is_dash  = cnt >= CNT_W'(DASH_MIN);
   assign at_space = cnt == CNT_W'(SPACE_GAP);
   assign at_end   = cnt == CNT_W'(END_GAP);

   // state register
   always_ff @(posedge clk) begin
      if (Reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         char_q <= 1'b0;
         seq_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         char_q <= char_nxt;
         seq_q  <= seq_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_inc;
      char_nxt  = char_q;
      seq_nxt   = seq_q;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (KeyDb) begin
               state_nxt = ST_PRESS;
               cnt_nxt   = CNT_W'(1);
            end
         end
         ST_PRESS: begin
            if (!KeyDb) begin
               if (!is_short) begin
                  state_nxt = ST_GAP;
                  cnt_nxt   = CNT_W'(1);
                  char_nxt  = 1'b1;
                  seq_nxt   = 1'b1;
               end else if (char_q) begin
                  // glitch press inside a character: gap restarts from release
                  state_nxt = ST_GAP;
                  cnt_nxt   = CNT_W'(1);
               end else begin
                  state_nxt = ST_IDLE;
                  cnt_nxt   = '0;
               end
            end
         end
         ST_GAP: begin
            // a new press wins over a Space/EndSeq falling on the same cycle
            if (KeyDb) begin
               state_nxt = ST_PRESS;
               cnt_nxt   = CNT_W'(1);
            end else if (at_end) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               seq_nxt   = 1'b0;
            end else if (at_space && char_q) begin
               char_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // output logic: symbol requests
   always_comb begin
      req_valid = 1'b0;
      req_sym   = SYM_DOT;
      case (state)
         ST_PRESS: begin
            if (!KeyDb && !is_short) begin
               req_valid = 1'b1;
               req_sym   = is_dash ? SYM_DASH : SYM_DOT;
            end
         end
         ST_GAP: begin
            if (!KeyDb) begin
               if (at_space && char_q) begin
                  req_valid = 1'b1;
                  req_sym   = SYM_SPACE;
               end else if (at_end && seq_q) begin
                  req_valid = 1'b1;
                  req_sym   = SYM_END;
               end
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- pulse emitter
   logic            active, pend_valid, pulse_last;
   sym_t            cur_sym, pend_sym;
   logic [PL_W-1:0] pcnt;

   assign pulse_last = active && (pcnt == PL_W'(PULSE_LEN - 1));

   always_ff @(posedge clk) begin
      if (Reset) begin
         active     <= 1'b0;
         cur_sym    <= SYM_DOT;
         pcnt       <= '0;
         pend_valid <= 1'b0;
         pend_sym   <= SYM_DOT;
         Overrun    <= 1'b0;
      end else if (!active || pulse_last) begin
         // emitter free next cycle: the slot drains first, a new request
         // then takes the slot, so pulses run back-to-back
         pcnt <= '0;
         if (pend_valid) begin
            active     <= 1'b1;
            cur_sym    <= pend_sym;
            pend_valid <= req_valid;
            pend_sym   <= req_sym;
         end else if (req_valid) begin
            active  <= 1'b1;
            cur_sym <= req_sym;
         end else begin
            active <= 1'b0;
         end
      end else begin
         pcnt <= pcnt + 1'b1;
         if (req_valid) begin
            if (!pend_valid) begin
               pend_valid <= 1'b1;
               pend_sym   <= req_sym;
            end else begin
               Overrun <= 1'b1;
            end
         end
      end
   end

   assign Dot    = active && (cur_sym == SYM_DOT);
   assign Dash   = active && (cur_sym == SYM_DASH);
   assign Space  = active && (cur_sym == SYM_SPACE);
   assign EndSeq = active && (cur_sym == SYM_END);

endmodule

// File: tb/tb_morse_key_classifier.sv
// -----------------------------------------------------------------------------
// tb_morse_key_classifier
//   Bench for morse_key_classifier. A timestamp-based model of the key timing
//   rules predicts every output each cycle; directed scenarios pin absolute
//   latencies and pulse widths with literal values. A second instance with
//   PULSE_LEN=100 exercises the pending slot and Overrun.
// -----------------------------------------------------------------------------
module tb_morse_key_classifier;

   localparam int DEB  = 4;
   localparam int DMIN = 8;
   localparam int DSHM = 40;
   localparam int SPG  = 60;
   localparam int ENG  = 140;
   localparam int PL   = 10;
   localparam int CMAX = 65535;

   // ---------------------------------------------------------------- clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic key = 1'b0;
   logic key2 = 1'b0;
   always #5 clk = ~clk;

   logic dot, dash, space, endseq, keydb, overrun;
   logic dot2, dash2, space2, endseq2, keydb2, overrun2;

   morse_key_classifier u_dut (
      .clk(clk), .Reset(rst), .Key(key),
      .Dot(dot), .Dash(dash), .Space(space), .EndSeq(endseq),
      .KeyDb(keydb), .Overrun(overrun)
   );

   morse_key_classifier #(.PULSE_LEN(100)) u_dut_ov (
      .clk(clk), .Reset(rst), .Key(key2),
      .Dot(dot2), .Dash(dash2), .Space(space2), .EndSeq(endseq2),
      .KeyDb(keydb2), .Overrun(overrun2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   typedef struct {int start; int sym;} pulse_t;
   pulse_t pq[$];
   bit     s2w[$];
   bit     model_ready = 1'b0;
   bit     kd0, kd1, m_db, m_char, m_seq, m_ov, flip;
   int     cyc = 0;
   int     mode, p_start, g_start, last_start, exp_sym;
   int     m_req, m_len, m_g, m_s;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         model_ready = 1'b1;
         kd0 = 0; kd1 = 0; m_db = 0; m_char = 0; m_seq = 0; m_ov = 0;
         s2w.delete(); pq.delete();
         mode = 0; p_start = 0; g_start = 0; last_start = -100000; exp_sym = -1;
      end else if (model_ready) begin
         m_req = -1;
         // classify against the debounced level seen during the ending cycle
         case (mode)
            0: if (m_db) begin mode = 1; p_start = cyc; end
            1: if (!m_db) begin
                  m_len = cyc - p_start;
                  if (m_len > CMAX) m_len = CMAX;
                  if (m_len >= DSHM)      m_req = 1;
                  else if (m_len >= DMIN) m_req = 0;
                  if (m_req >= 0) begin m_char = 1; m_seq = 1; end
                  if (m_char) begin mode = 2; g_start = cyc; end
                  else mode = 0;
               end
            default: begin
               m_g = cyc - g_start;
               if (m_db) begin mode = 1; p_start = cyc; end
               else if (m_g == ENG) begin
                  if (m_seq) m_req = 3;
                  m_seq = 0; mode = 0;
               end else if (m_g == SPG && m_char) begin m_req = 2; m_char = 0; end
            end
         endcase
         // emitter: free-or-ending emitter, or empty slot, accepts
         if (m_req >= 0) begin
            if (last_start <= cyc) begin
               m_s = (last_start + PL > cyc) ? last_start + PL : cyc;
               pq.push_back('{start: m_s, sym: m_req});
               last_start = m_s;
            end else begin
               m_ov = 1;
            end
         end
         // debounced level flips once the last DEB synced samples all disagree
         s2w.push_back(kd1);
         if (s2w.size() > DEB) void'(s2w.pop_front());
         flip = (s2w.size() == DEB);
         foreach (s2w[i]) if (s2w[i] == m_db) flip = 0;
         if (flip) m_db = !m_db;
         kd1 = kd0; kd0 = key;
         while (pq.size() > 0 && pq[0].start + PL <= cyc) void'(pq.pop_front());
         exp_sym = (pq.size() > 0 && pq[0].start <= cyc) ? pq[0].sym : -1;
      end
   end

   // ---------------------------------------------------------------- scoreboard compare
   logic [5:0] got_v, exp_v;
   always @(negedge clk) begin
      if (model_ready) begin
         got_v = {dot, dash, space, endseq, keydb, overrun};
         exp_v = {exp_sym == 0, exp_sym == 1, exp_sym == 2, exp_sym == 3, m_db, m_ov};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            if (n_fail <= 20)
               $display("FAIL model_cmp cyc=%0d got=%b exp=%b (Dot Dash Space EndSeq KeyDb Overrun)",
                        cyc, got_v, exp_v);
         end
      end
   end

   // ---------------------------------------------------------------- event monitor
   int ncount = 0;
   int rise_n[5], hi_n[5], last_rise[5];
   int base_r[5], base_h[5];
   logic [4:0] prev_o = '0, cur_o;
   int dot2_run = 0, dot2_max = 0, dot2_tot = 0, oth2_tot = 0;

   always @(negedge clk) begin
      ncount++;
      cur_o = {keydb, endseq, space, dash, dot};
      for (int i = 0; i < 5; i++) begin
         if (cur_o[i] && !prev_o[i]) begin rise_n[i]++; last_rise[i] = ncount; end
         if (cur_o[i]) hi_n[i]++;
      end
      prev_o = cur_o;
      if (dot2) begin
         dot2_run++; dot2_tot++;
         if (dot2_run > dot2_max) dot2_max = dot2_run;
      end else dot2_run = 0;
      if (dash2 || space2 || endseq2 || keydb2) oth2_tot++;
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic cycles(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic press(input int on_c, input int off_c);
      key = 1'b1; cycles(on_c);
      key = 1'b0; cycles(off_c);
   endtask

   task automatic snap();
      for (int i = 0; i < 5; i++) begin base_r[i] = rise_n[i]; base_h[i] = hi_n[i]; end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; cycles(n); rst = 1'b0;
   endtask

   // ---------------------------------------------------------------- stimulus
   int mark, on_c, off_c, sel;

   initial begin
      for (int i = 0; i < 5; i++) begin rise_n[i] = 0; hi_n[i] = 0; last_rise[i] = 0; end
      cycles(2);
      do_reset(3);
      check("reset_outputs", int'({dot, dash, space, endseq, keydb, overrun}), 0);

      // single Dot, then Space and EndSeq from the gap
      snap();
      key = 1'b1; cycles(20); key = 1'b0; mark = ncount;
      cycles(200);
      check("dot_rise_latency", last_rise[0] - mark, 7);
      check("dot_width", hi_n[0] - base_h[0], 10);
      check("dot_count", rise_n[0] - base_r[0], 1);
      check("dash_none", hi_n[1] - base_h[1], 0);
      check("space_at_gap60", last_rise[2] - mark, 67);
      check("space_width", hi_n[2] - base_h[2], 10);
      check("endseq_at_gap140", last_rise[3] - mark, 147);
      check("endseq_width", hi_n[3] - base_h[3], 10);

      // single Dash
      snap();
      key = 1'b1; cycles(50); key = 1'b0; mark = ncount;
      cycles(200);
      check("dash_rise_latency", last_rise[1] - mark, 7);
      check("dash_width", hi_n[1] - base_h[1], 10);
      check("dash_no_dot", rise_n[0] - base_r[0], 0);

      // glitch filtered by debounce; short press passes debounce but is ignored
      snap();
      press(3, 50);
      check("glitch_keydb_steady", rise_n[4] - base_r[4], 0);
      snap();
      press(6, 200);
      check("short_keydb_rise", rise_n[4] - base_r[4], 1);
      check("short_keydb_width", hi_n[4] - base_h[4], 6);
      check("short_no_symbols", (rise_n[0] - base_r[0]) + (rise_n[1] - base_r[1]) +
                                (rise_n[2] - base_r[2]) + (rise_n[3] - base_r[3]), 0);

      // Dot + Dash character, one Space, one EndSeq
      snap();
      press(20, 30);
      key = 1'b1; cycles(50); key = 1'b0; mark = ncount;
      cycles(250);
      check("char_dot", rise_n[0] - base_r[0], 1);
      check("char_dash", rise_n[1] - base_r[1], 1);
      check("char_space_count", rise_n[2] - base_r[2], 1);
      check("char_space_time", last_rise[2] - mark, 67);
      check("char_endseq_time", last_rise[3] - mark, 147);

      // press at gap 100: Space for that gap but no EndSeq
      snap();
      press(20, 30);
      press(50, 100);
      key = 1'b1; cycles(20); key = 1'b0; mark = ncount;
      cycles(250);
      check("gap100_space_count", rise_n[2] - base_r[2], 2);
      check("gap100_endseq_count", rise_n[3] - base_r[3], 1);
      check("gap100_endseq_time", last_rise[3] - mark, 147);

      // reset during a Dash pulse
      key = 1'b1; cycles(50); key = 1'b0; cycles(10);
      check("dash_before_reset", int'(dash), 1);
      do_reset(1);
      check("dash_after_reset", int'(dash), 0);
      snap();
      cycles(200);
      check("quiet_after_reset", (hi_n[0] - base_h[0]) + (hi_n[1] - base_h[1]) +
                                 (hi_n[2] - base_h[2]) + (hi_n[3] - base_h[3]) +
                                 int'(overrun), 0);

      // randomized key traffic against the model; gaps avoid exact 60/140 ties
      for (int n = 0; n < 50; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 2)      on_c = $urandom_range(5, 7);
         else if (sel < 6) on_c = $urandom_range(DMIN, DSHM - 1);
         else              on_c = $urandom_range(DSHM, 70);
         sel = $urandom_range(0, 9);
         if (sel < 5)      off_c = $urandom_range(10, 50);
         else if (sel < 8) off_c = $urandom_range(70, 130);
         else              off_c = $urandom_range(150, 220);
         press(on_c, off_c);
      end
      cycles(250);

      // PULSE_LEN=100 instance: back-to-back Dots, third dropped
      do_reset(2);
      check("ov_inst_reset_overrun", int'(overrun2), 0);
      for (int n = 0; n < 3; n++) begin
         key2 = 1'b1; cycles(20); key2 = 1'b0; cycles(10);
      end
      cycles(450);
      check("ov_inst_dot_total", dot2_tot, 200);
      check("ov_inst_dot_contig", dot2_max, 200);
      check("ov_inst_overrun_set", int'(overrun2), 1);
      do_reset(1);
      check("ov_inst_overrun_cleared", int'(overrun2), 0);
      check("ov_inst_keydb_seen", int'(oth2_tot > 0), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
